sdhci_card_cmd: RTL and testbench

Card-side responder for the SD CMD line, placed directly downstream of the SDHCI host's `sd_cmd_o`/`sd_cmd_en_o` pins and driving `sd_cmd_i` back into the host.

- Receives 48-bit host command frames, validates framing and CRC7, and exposes the index and argument to card logic.
- After an NCR gap, returns a 48-bit R1-format response carrying the card-supplied status word.
- Synthesizable; usable as the CMD half of a card model in the simulation VIP or on an FPGA card emulator.

---
 rtl/sdhci_card_pkg.sv | 17 +
 rtl/sdhci_crc7.sv | 34 +++
 rtl/sdhci_card_cmd.sv | 220 ++++++++++++++++++++++
 tb/tb_sdhci_card_cmd.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sdhci_card_pkg.sv
// rtl/sdhci_card_pkg.sv - shared types and constants for the SD card CMD-line responder
package sdhci_card_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_NCR,
        ST_TX
    } state_e;

    localparam int CmdFrameLen = 48;
    localparam int CrcLen      = 7;

    localparam logic [5:0] NoRespIndex = 6'd0;

endpackage

// File: rtl/sdhci_crc7.sv
// rtl/sdhci_crc7.sv - serial CRC7 (x^7 + x^3 + 1), zero seed, MSB first
module sdhci_crc7 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = bit_i ^ crc_q[6];
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = 7'd0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= 7'd0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sdhci_card_cmd.sv
// rtl/sdhci_card_cmd.sv - card-side CMD responder: receive 48-bit commands, answer with R1
// SDHCI_CARD_CRC_CHECK_EN enables checking of the received command CRC7.
module sdhci_card_cmd #(
    parameter int NcrCycles = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sd_clk_i,
    input  logic        sd_cmd_i,
    input  logic        sd_cmd_en_i,
    output logic        sd_cmd_o,
    output logic        sd_cmd_en_o,
    input  logic [31:0] status_i,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        crc_err_o,
    output logic        frame_err_o
);
    import sdhci_card_pkg::*;

    localparam logic [5:0] RxBits     = 6'(CmdFrameLen - 2);
    localparam logic [5:0] RxCrcStop  = 6'(CrcLen + 1);
    localparam logic [5:0] TxCrcFirst = 6'(CmdFrameLen - CrcLen - 1);
    localparam logic [5:0] TxLast     = 6'(CmdFrameLen - 1);
    localparam logic [6:0] NcrLimit   = 7'(NcrCycles);
`ifdef SDHCI_CARD_CRC_CHECK_EN
    localparam bit CrcCheckEn = 1'b1;
`else
    localparam bit CrcCheckEn = 1'b0;
`endif

    state_e      state_q, state_d;
    logic        sd_clk_q, sd_clk_d;
    logic [46:0] rx_sr_q, rx_sr_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [47:0] tx_sr_q, tx_sr_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    logic [6:0]  ncr_cnt_q, ncr_cnt_d;
    logic        sd_cmd_q, sd_cmd_d, sd_cmd_en_q, sd_cmd_en_d;
    logic        cmd_valid_q, cmd_valid_d, crc_err_q, crc_err_d, frame_err_q, frame_err_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        rise, fall;
    logic        rx_crc_clear, rx_crc_en, tx_crc_clear, tx_crc_en, tx_crc_bit;
    logic [6:0]  rx_crc, tx_crc;
    logic [5:0]  tx_next;
    logic        tx_bit;

    assign rise = sd_clk_i & ~sd_clk_q;
    assign fall = ~sd_clk_i & sd_clk_q;

    sdhci_crc7 u_rx_crc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(rx_crc_clear),
        .en_i   (rx_crc_en),
        .bit_i  (sd_cmd_i),
        .crc_o  (rx_crc)
    );

    sdhci_crc7 u_tx_crc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(tx_crc_clear),
        .en_i   (tx_crc_en),
        .bit_i  (tx_crc_bit),
        .crc_o  (tx_crc)
    );

    always_comb begin
        state_d      = state_q;
        sd_clk_d     = sd_clk_i;
        rx_sr_d      = rx_sr_q;
        rx_cnt_d     = rx_cnt_q;
        tx_sr_d      = tx_sr_q;
        tx_cnt_d     = tx_cnt_q;
        ncr_cnt_d    = ncr_cnt_q;
        sd_cmd_d     = sd_cmd_q;
        sd_cmd_en_d  = sd_cmd_en_q;
        cmd_valid_d  = 1'b0;
        crc_err_d    = 1'b0;
        frame_err_d  = 1'b0;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        rx_crc_clear = 1'b0;
        rx_crc_en    = 1'b0;
        tx_crc_clear = 1'b0;
        tx_crc_en    = 1'b0;
        tx_crc_bit   = 1'b0;
        tx_next      = tx_cnt_q + 6'd1;
        // Feeding the CRC its own MSB clocks zeros in, so the register serialises itself out.
        tx_bit       = (tx_next >= TxCrcFirst && tx_next < TxLast) ? tx_crc[6] : tx_sr_q[47];

        case (state_q)
            ST_IDLE: begin
                if (rise && sd_cmd_en_i && !sd_cmd_i) begin
                    state_d      = ST_RX;
                    rx_cnt_d     = RxBits;
                    rx_crc_clear = 1'b1;
                end
            end
            ST_RX: begin
                if (rise) begin
                    if (!sd_cmd_en_i) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        rx_sr_d   = {rx_sr_q[45:0], sd_cmd_i};
                        rx_cnt_d  = rx_cnt_q - 6'd1;
                        rx_crc_en = (rx_cnt_q >= RxCrcStop);
                        if (rx_cnt_q == 6'd0) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!rx_sr_q[46] || !rx_sr_q[0]) begin
                    frame_err_d = 1'b1;
                end else if (CrcCheckEn && (rx_crc != rx_sr_q[7:1])) begin
                    crc_err_d = 1'b1;
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_index_d = rx_sr_q[45:40];
                    cmd_arg_d   = rx_sr_q[39:8];
                    if (rx_sr_q[45:40] != NoRespIndex) begin
                        tx_sr_d      = {2'b00, rx_sr_q[45:40], status_i, 7'd0, 1'b1};
                        tx_crc_clear = 1'b1;
                        ncr_cnt_d    = 7'd0;
                        state_d      = ST_NCR;
                    end
                end
            end
            ST_NCR: begin
                if (sd_cmd_en_i) begin
                    sd_cmd_en_d = 1'b0;
                    sd_cmd_d    = 1'b1;
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (rise && ncr_cnt_q < NcrLimit) begin
                    ncr_cnt_d = ncr_cnt_q + 7'd1;
                end else if (fall && ncr_cnt_q >= NcrLimit) begin
                    sd_cmd_en_d = 1'b1;
                    sd_cmd_d    = tx_sr_q[47];
                    tx_crc_en   = 1'b1;
                    tx_crc_bit  = tx_sr_q[47];
                    tx_sr_d     = tx_sr_q << 1;
                    tx_cnt_d    = 6'd0;
                    state_d     = ST_TX;
                end
            end
            ST_TX: begin
                if (sd_cmd_en_i) begin
                    sd_cmd_en_d = 1'b0;
                    sd_cmd_d    = 1'b1;
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (fall) begin
                    if (tx_cnt_q == TxLast) begin
                        sd_cmd_en_d = 1'b0;
                        sd_cmd_d    = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        sd_cmd_d   = tx_bit;
                        tx_sr_d    = tx_sr_q << 1;
                        tx_cnt_d   = tx_next;
                        tx_crc_en  = (tx_next < TxLast);
                        tx_crc_bit = tx_bit;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sd_clk_q    <= 1'b0;
            rx_sr_q     <= '0;
            rx_cnt_q    <= '0;
            tx_sr_q     <= '0;
            tx_cnt_q    <= '0;
            ncr_cnt_q   <= '0;
            sd_cmd_q    <= 1'b1;
            sd_cmd_en_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
        end else begin
            state_q     <= state_d;
            sd_clk_q    <= sd_clk_d;
            rx_sr_q     <= rx_sr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_sr_q     <= tx_sr_d;
            tx_cnt_q    <= tx_cnt_d;
            ncr_cnt_q   <= ncr_cnt_d;
            sd_cmd_q    <= sd_cmd_d;
            sd_cmd_en_q <= sd_cmd_en_d;
            cmd_valid_q <= cmd_valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
        end
    end

    assign sd_cmd_o    = sd_cmd_q;
    assign sd_cmd_en_o = sd_cmd_en_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_index_o = cmd_index_q;
    assign cmd_arg_o   = cmd_arg_q;
    assign crc_err_o   = crc_err_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_sdhci_card_cmd.sv
// tb/tb_sdhci_card_cmd.sv - directed self-checking bench for sdhci_card_cmd
module tb_sdhci_card_cmd;

    logic        clk = 1'b0;
    logic        rst;
    logic        sd_clk;
    logic        sd_cmd_i;
    logic        sd_cmd_en_i;
    logic [31:0] status_i;
    logic        sd_cmd_o;
    logic        sd_cmd_en_o;
    logic        cmd_valid_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic        crc_err_o;
    logic        frame_err_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_valid = 0, n_crc = 0, n_frame = 0, n_en = 0;
    int v0, c0, f0, e0;

    logic        resp_en  [1:64];
    logic        resp_bit [1:64];
    logic        s_en, s_bit, all_en;
    logic [47:0] resp;

    always #5 clk = ~clk;

    sdhci_card_cmd #(.NcrCycles(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sd_clk_i   (sd_clk),
        .sd_cmd_i   (sd_cmd_i),
        .sd_cmd_en_i(sd_cmd_en_i),
        .sd_cmd_o   (sd_cmd_o),
        .sd_cmd_en_o(sd_cmd_en_o),
        .status_i   (status_i),
        .cmd_valid_o(cmd_valid_o),
        .cmd_index_o(cmd_index_o),
        .cmd_arg_o  (cmd_arg_o),
        .crc_err_o  (crc_err_o),
        .frame_err_o(frame_err_o)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid_o) n_valid++;
            if (crc_err_o)   n_crc++;
            if (frame_err_o) n_frame++;
            if (sd_cmd_en_o) n_en++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // One SD clock period: 2 clk low, 2 clk high; card outputs sampled at the host rising edge.
    task automatic sd_tick(input logic en, input logic b, output logic o_en, output logic o_bit);
        sd_clk      = 1'b0;
        sd_cmd_en_i = en;
        sd_cmd_i    = b;
        repeat (2) @(negedge clk);
        sd_clk = 1'b1;
        o_en   = sd_cmd_en_o;
        o_bit  = sd_cmd_o;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                            input logic endb);
        logic [47:0] fr;
        logic        d0, d1;
        fr = {1'b0, 1'b1, idx, arg, crc, endb};
        for (int i = 47; i >= 0; i--) sd_tick(1'b1, fr[i], d0, d1);
    endtask

    task automatic run_idle(input int n);
        logic a, b;
        for (int i = 1; i <= n; i++) begin
            sd_tick(1'b0, 1'b1, a, b);
            if (i <= 64) begin
                resp_en[i]  = a;
                resp_bit[i] = b;
            end
        end
    endtask

    initial begin
        rst = 1'b1; sd_clk = 1'b0; sd_cmd_i = 1'b1; sd_cmd_en_i = 1'b0; status_i = 32'h0000_0120;
        repeat (3) @(negedge clk);
        check("rst_cmd_o",    64'(sd_cmd_o), 64'd1);
        check("rst_cmd_en_o", 64'(sd_cmd_en_o), 64'd0);
        check("rst_valid",    64'(cmd_valid_o), 64'd0);
        check("rst_index",    64'(cmd_index_o), 64'd0);
        check("rst_arg",      64'(cmd_arg_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // CMD0: accepted, never answered
        v0 = n_valid; e0 = n_en;
        send_cmd(6'd0, 32'h0, 7'h4A, 1'b1);
        run_idle(20);
        check("cmd0_valid",   64'(n_valid - v0), 64'd1);
        check("cmd0_index",   64'(cmd_index_o), 64'd0);
        check("cmd0_no_resp", 64'(n_en - e0), 64'd0);

        // CMD8: R1 response after NCR, status frozen at acceptance
        v0 = n_valid;
        send_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1);
        status_i = 32'hFFFF_FFFF;
        run_idle(55);
        status_i = 32'h0000_0120;
        check("cmd8_valid", 64'(n_valid - v0), 64'd1);
        check("cmd8_index", 64'(cmd_index_o), 64'd8);
        check("cmd8_arg",   64'(cmd_arg_o), 64'h1AA);
        check("cmd8_ncr_quiet", 64'({resp_en[1], resp_en[2]}), 64'd0);
        check("cmd8_start_en",  64'(resp_en[3]), 64'd1);
        all_en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            resp[47 - i] = resp_bit[3 + i];
            all_en       = all_en & resp_en[3 + i];
        end
        check("cmd8_resp_en", 64'(all_en), 64'd1);
        check("cmd8_resp", 64'(resp),
              64'({2'b00, 6'd8, 32'h0000_0120, crc7({2'b00, 6'd8, 32'h0000_0120}), 1'b1}));
        check("cmd8_release", 64'({resp_en[51], resp_bit[51]}), 64'b01);

        // CMD55 with corrupted CRC
        v0 = n_valid; c0 = n_crc; e0 = n_en;
        send_cmd(6'd55, 32'h0, 7'h33, 1'b1);
        run_idle(60);
`ifdef SDHCI_CARD_CRC_CHECK_EN
        check("bad_crc_err",     64'(n_crc - c0), 64'd1);
        check("bad_crc_valid",   64'(n_valid - v0), 64'd0);
        check("bad_crc_no_resp", 64'(n_en - e0), 64'd0);
`else
        check("bad_crc_err",   64'(n_crc - c0), 64'd0);
        check("bad_crc_valid", 64'(n_valid - v0), 64'd1);
        check("bad_crc_index", 64'(cmd_index_o), 64'd55);
`endif

        // end bit 0, then a good CMD55
        f0 = n_frame; v0 = n_valid;
        send_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b0);
        run_idle(4);
        check("endbit_frame_err", 64'(n_frame - f0), 64'd1);
        check("endbit_no_valid",  64'(n_valid - v0), 64'd0);
        send_cmd(6'd55, 32'h0, 7'h32, 1'b1);
        run_idle(60);
        check("cmd55_valid", 64'(n_valid - v0), 64'd1);
        check("cmd55_index", 64'(cmd_index_o), 64'd55);

        // host collides mid-response
        f0 = n_frame;
        send_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1);
        run_idle(10);
        check("coll_tx_active", 64'(sd_cmd_en_o), 64'd1);
        sd_tick(1'b1, 1'b1, s_en, s_bit);
        check("coll_release",   64'({sd_cmd_en_o, sd_cmd_o}), 64'b01);
        check("coll_frame_err", 64'(n_frame - f0), 64'd1);
        e0 = n_en; v0 = n_valid;
        run_idle(60);
        check("coll_idle", 64'(n_en - e0), 64'd0);
        send_cmd(6'd0, 32'h0, 7'h4A, 1'b1);
        run_idle(5);
        check("coll_then_cmd0", 64'(n_valid - v0), 64'd1);

        // reset mid-TX
        send_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1);
        run_idle(10);
        check("rst_tx_active", 64'(sd_cmd_en_o), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_async_release", 64'({sd_cmd_en_o, sd_cmd_o}), 64'b01);
        check("rst_async_index",   64'(cmd_index_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v0 = n_valid;
        send_cmd(6'd0, 32'h0, 7'h4A, 1'b1);
        run_idle(5);
        check("rst_then_cmd0", 64'(n_valid - v0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
